// File: rtl/mole_field_pkg.sv
// mole_field_pkg: shared slot-state encoding and combo width for the mole field.
// Revision 1.0
`default_nettype none

package mole_field_pkg;

    localparam int COMBO_W = 3;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_UP_GOOD = 2'd1,
        S_UP_BAD  = 2'd2,
        S_WHACKED = 2'd3
    } slot_state_e;

    function automatic int timer_width(input int a, input int b);
        return $clog2(((a > b) ? a : b) + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mole_field_if.sv
// mole_field_if: game-controller side bundle of the mole field (strobes, hits, display).
// Revision 1.0
`default_nettype none

interface mole_field_if #(
    parameter int N_CELLS = 16,
    parameter int SCORE_W = 10
);
    logic                      enable;
    logic                      clear;
    logic [N_CELLS-1:0]        spawn_good;
    logic [N_CELLS-1:0]        spawn_bad;
    logic [N_CELLS-1:0]        hit;
    logic [N_CELLS-1:0]        good_mole;
    logic [N_CELLS-1:0]        bad_mole;
    logic signed [SCORE_W-1:0] score;
    logic [2:0]                combo;
    logic                      hit_good;
    logic                      hit_bad;

    modport master (
        output enable, clear, spawn_good, spawn_bad, hit,
        input  good_mole, bad_mole, score, combo, hit_good, hit_bad
    );

    modport slave (
        input  enable, clear, spawn_good, spawn_bad, hit,
        output good_mole, bad_mole, score, combo, hit_good, hit_bad
    );
endinterface

`default_nettype wire

// File: rtl/mole_slot.sv
// mole_slot: one mole slot -- lifetime/cooldown FSM, hit edge detect, scoring events.
// Revision 1.0
`default_nettype none

module mole_slot
    import mole_field_pkg::*;
#(
    parameter int LIFE_CYCLES = 50,
    parameter int COOL_CYCLES = 4
) (
    input  logic Clk,
    input  logic Set,
    input  logic enable_i,
    input  logic clear_i,
    input  logic spawn_good_i,
    input  logic spawn_bad_i,
    input  logic hit_i,
    output logic good_mole_o,
    output logic bad_mole_o,
    output logic good_rise_o,
    output logic bad_rise_o,
    output logic miss_o
);
    localparam int TIMER_W = timer_width(LIFE_CYCLES, COOL_CYCLES);
    localparam logic [TIMER_W-1:0] C_LIFE = TIMER_W'(LIFE_CYCLES);
    localparam logic [TIMER_W-1:0] C_COOL = TIMER_W'(COOL_CYCLES);
    localparam logic [TIMER_W-1:0] C_ONE  = TIMER_W'(1);

    slot_state_e        state_q;
    logic [TIMER_W-1:0] timer_q;
    logic               hit_q;
    logic               good_mole_q;
    logic               bad_mole_q;

    logic w_active;
    logic w_rise;
    logic w_expire;

    assign w_active = enable_i & ~clear_i;
    assign w_rise   = hit_i & ~hit_q;
    assign w_expire = (timer_q == C_ONE);

    // Scoring events are combinational so the shared score lands on the same edge.
    assign good_rise_o = w_active & (state_q == S_UP_GOOD) & w_rise;
    assign bad_rise_o  = w_active & (state_q == S_UP_BAD)  & w_rise;
    assign miss_o      = w_active & (state_q == S_UP_GOOD) & ~w_rise & w_expire;

    assign good_mole_o = good_mole_q;
    assign bad_mole_o  = bad_mole_q;

    always_ff @(posedge Clk or negedge Set) begin
        if (!Set) begin
            state_q     <= S_IDLE;
            timer_q     <= '0;
            hit_q       <= 1'b0;
            good_mole_q <= 1'b0;
            bad_mole_q  <= 1'b0;
        end else begin
            hit_q <= hit_i;
            if (!w_active) begin
                state_q     <= S_IDLE;
                timer_q     <= '0;
                good_mole_q <= 1'b0;
                bad_mole_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (spawn_good_i) begin
                            state_q     <= S_UP_GOOD;
                            timer_q     <= C_LIFE;
                            good_mole_q <= 1'b1;
                        end else if (spawn_bad_i) begin
                            state_q    <= S_UP_BAD;
                            timer_q    <= C_LIFE;
                            bad_mole_q <= 1'b1;
                        end
                    end
                    S_UP_GOOD, S_UP_BAD: begin
                        if (w_rise) begin
                            state_q     <= S_WHACKED;
                            timer_q     <= C_COOL;
                            good_mole_q <= 1'b0;
                            bad_mole_q  <= 1'b0;
                        end else if (w_expire) begin
                            state_q     <= S_IDLE;
                            timer_q     <= '0;
                            good_mole_q <= 1'b0;
                            bad_mole_q  <= 1'b0;
                        end else begin
                            timer_q <= timer_q - C_ONE;
                        end
                    end
                    S_WHACKED: begin
                        if (w_expire) begin
                            state_q <= S_IDLE;
                            timer_q <= '0;
                        end else begin
                            timer_q <= timer_q - C_ONE;
                        end
                    end
                    default: begin
                        state_q     <= S_IDLE;
                        timer_q     <= '0;
                        good_mole_q <= 1'b0;
                        bad_mole_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mole_field.sv
// mole_field: N_CELLS mole slots plus the shared saturating score and combo multiplier.
// Revision 1.0
`default_nettype none

module mole_field
    import mole_field_pkg::*;
#(
    parameter int N_CELLS     = 16,
    parameter int LIFE_CYCLES = 50,
    parameter int COOL_CYCLES = 4,
    parameter int SCORE_W     = 10,
    parameter int GOOD_PTS    = 1,
    parameter int BAD_PTS     = 2,
    parameter int COMBO_MAX   = 4
) (
    input  logic          Clk,
    input  logic          Set,
    mole_field_if.slave   bus
);
    localparam int CALC_W = SCORE_W + 6;
    localparam int CNT_W  = $clog2(N_CELLS + 1);

    localparam logic signed [CALC_W-1:0] C_GOOD = CALC_W'(GOOD_PTS);
    localparam logic signed [CALC_W-1:0] C_BAD  = CALC_W'(BAD_PTS);
    localparam logic signed [CALC_W-1:0] C_MAX  = CALC_W'((1 << (SCORE_W - 1)) - 1);
    localparam logic signed [CALC_W-1:0] C_MIN  = ~C_MAX;
    localparam logic [COMBO_W-1:0]       C_COMBO_MAX = COMBO_W'(COMBO_MAX);
    localparam logic [COMBO_W-1:0]       C_COMBO_ONE = COMBO_W'(1);

    logic [N_CELLS-1:0] w_good_rise;
    logic [N_CELLS-1:0] w_bad_rise;
    logic [N_CELLS-1:0] w_miss;
    logic [N_CELLS-1:0] w_good_mole;
    logic [N_CELLS-1:0] w_bad_mole;

    logic signed [SCORE_W-1:0] score_q, score_d;
    logic [COMBO_W-1:0]        combo_q, combo_d;
    logic                      hit_good_q;
    logic                      hit_bad_q;

    logic [CNT_W-1:0]          w_good_cnt;
    logic [CNT_W-1:0]          w_bad_cnt;
    logic signed [CALC_W-1:0]  w_score_ext;
    logic signed [CALC_W-1:0]  w_delta;
    logic signed [CALC_W-1:0]  w_sum;

    for (genvar i = 0; i < N_CELLS; i++) begin : g_slot
        mole_slot #(
            .LIFE_CYCLES (LIFE_CYCLES),
            .COOL_CYCLES (COOL_CYCLES)
        ) u_slot (
            .Clk          (Clk),
            .Set          (Set),
            .enable_i     (bus.enable),
            .clear_i      (bus.clear),
            .spawn_good_i (bus.spawn_good[i]),
            .spawn_bad_i  (bus.spawn_bad[i]),
            .hit_i        (bus.hit[i]),
            .good_mole_o  (w_good_mole[i]),
            .bad_mole_o   (w_bad_mole[i]),
            .good_rise_o  (w_good_rise[i]),
            .bad_rise_o   (w_bad_rise[i]),
            .miss_o       (w_miss[i])
        );
    end

    always_comb begin
        w_good_cnt = '0;
        w_bad_cnt  = '0;
        for (int i = 0; i < N_CELLS; i++) begin
            w_good_cnt = w_good_cnt + CNT_W'(w_good_rise[i]);
            w_bad_cnt  = w_bad_cnt  + CNT_W'(w_bad_rise[i]);
        end
    end

    // Wide intermediate keeps the sum exact so saturation never sees a wrapped value.
    always_comb begin
        w_score_ext = {{(CALC_W - SCORE_W){score_q[SCORE_W-1]}}, score_q};
        w_delta     = CALC_W'(w_good_cnt) * C_GOOD * CALC_W'(combo_q)
                    - CALC_W'(w_bad_cnt) * C_BAD;
        w_sum       = w_score_ext + w_delta;
        if (w_sum > C_MAX) begin
            score_d = C_MAX[SCORE_W-1:0];
        end else if (w_sum < C_MIN) begin
            score_d = C_MIN[SCORE_W-1:0];
        end else begin
            score_d = w_sum[SCORE_W-1:0];
        end
    end

    always_comb begin
        combo_d = combo_q;
        if ((|w_bad_rise) || (|w_miss)) begin
            combo_d = C_COMBO_ONE;
        end else if (|w_good_rise) begin
            combo_d = (combo_q >= C_COMBO_MAX) ? C_COMBO_MAX : combo_q + C_COMBO_ONE;
        end
    end

    always_ff @(posedge Clk or negedge Set) begin
        if (!Set) begin
            score_q    <= '0;
            combo_q    <= C_COMBO_ONE;
            hit_good_q <= 1'b0;
            hit_bad_q  <= 1'b0;
        end else if (bus.clear) begin
            score_q    <= '0;
            combo_q    <= C_COMBO_ONE;
            hit_good_q <= 1'b0;
            hit_bad_q  <= 1'b0;
        end else if (bus.enable) begin
            score_q    <= score_d;
            combo_q    <= combo_d;
            hit_good_q <= |w_good_rise;
            hit_bad_q  <= |w_bad_rise;
        end else begin
            hit_good_q <= 1'b0;
            hit_bad_q  <= 1'b0;
        end
    end

    assign bus.good_mole = w_good_mole;
    assign bus.bad_mole  = w_bad_mole;
    assign bus.score     = score_q;
    assign bus.combo     = combo_q;
    assign bus.hit_good  = hit_good_q;
    assign bus.hit_bad   = hit_bad_q;

endmodule

`default_nettype wire

// File: tb/tb_mole_field.sv
// tb_mole_field: randomized scoreboard bench for mole_field against a slot-count reference model.
// Revision 1.0
`default_nettype none

module tb_mole_field;
    localparam int N       = 16;
    localparam int LIFE    = 50;
    localparam int COOL    = 4;
    localparam int SW      = 10;
    localparam int GPTS    = 1;
    localparam int BPTS    = 2;
    localparam int CMAX    = 4;
    localparam int SMAX    = (1 << (SW - 1)) - 1;
    localparam int SMIN    = -(1 << (SW - 1));

    typedef struct {
        int gm;
        int bm;
        int sc;
        int cb;
        int hg;
        int hb;
    } exp_t;

    logic clk;
    logic set_n;

    mole_field_if #(.N_CELLS(N), .SCORE_W(SW)) bus ();

    mole_field #(
        .N_CELLS     (N),
        .LIFE_CYCLES (LIFE),
        .COOL_CYCLES (COOL),
        .SCORE_W     (SW),
        .GOOD_PTS    (GPTS),
        .BAD_PTS     (BPTS),
        .COMBO_MAX   (CMAX)
    ) dut (
        .Clk (clk),
        .Set (set_n),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   tests_run;
    int   tests_failed;
    exp_t exp_q[$];

    // Reference model: remaining visible cycles and remaining cooldown per slot.
    int        m_up   [N];
    int        m_cool [N];
    bit        m_good [N];
    bit [N-1:0] m_prev;
    int        m_score;
    int        m_combo;
    int        m_hg;
    int        m_hb;

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_up[i] = 0; m_cool[i] = 0; m_good[i] = 0;
        end
        m_prev = '0; m_score = 0; m_combo = 1; m_hg = 0; m_hb = 0;
    endtask

    task automatic model_edge();
        bit [N-1:0] rise;
        int ng, nb;
        bit miss;
        if (!set_n) begin
            model_reset();
            return;
        end
        rise   = bus.hit & ~m_prev;
        m_prev = bus.hit;
        m_hg = 0; m_hb = 0;
        if (bus.clear || !bus.enable) begin
            for (int i = 0; i < N; i++) begin
                m_up[i] = 0; m_cool[i] = 0;
            end
            if (bus.clear) begin
                m_score = 0; m_combo = 1;
            end
            return;
        end
        ng = 0; nb = 0; miss = 0;
        for (int i = 0; i < N; i++) begin
            if (m_up[i] > 0) begin
                if (rise[i]) begin
                    if (m_good[i]) ng++; else nb++;
                    m_up[i]   = 0;
                    m_cool[i] = COOL;
                end else begin
                    m_up[i]--;
                    if (m_up[i] == 0 && m_good[i]) miss = 1;
                end
            end else if (m_cool[i] > 0) begin
                m_cool[i]--;
            end else if (bus.spawn_good[i]) begin
                m_up[i] = LIFE; m_good[i] = 1;
            end else if (bus.spawn_bad[i]) begin
                m_up[i] = LIFE; m_good[i] = 0;
            end
        end
        m_score = m_score + ng * GPTS * m_combo - nb * BPTS;
        if (m_score > SMAX) m_score = SMAX;
        if (m_score < SMIN) m_score = SMIN;
        if (nb > 0 || miss)  m_combo = 1;
        else if (ng > 0)     m_combo = (m_combo + 1 > CMAX) ? CMAX : m_combo + 1;
        m_hg = (ng > 0);
        m_hb = (nb > 0);
    endtask

    function automatic exp_t model_view();
        exp_t e;
        e.gm = 0; e.bm = 0;
        for (int i = 0; i < N; i++) begin
            if (m_up[i] > 0 &&  m_good[i]) e.gm |= (1 << i);
            if (m_up[i] > 0 && !m_good[i]) e.bm |= (1 << i);
        end
        e.sc = m_score; e.cb = m_combo; e.hg = m_hg; e.hb = m_hb;
        return e;
    endfunction

    task automatic chk(input string nm, input int act, input int req);
        tests_run++;
        if (act !== req) begin
            tests_failed++;
            $display("FAIL %s at %0t: got %0d (0x%0h) expected %0d (0x%0h)",
                     nm, $time, act, act, req, req);
        end
    endtask

    // Monitor: compares every registered output one step after each active edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("good_mole", int'(bus.good_mole), e.gm);
                chk("bad_mole",  int'(bus.bad_mole),  e.bm);
                chk("score",     int'($signed(bus.score)), e.sc);
                chk("combo",     int'(bus.combo),     e.cb);
                chk("hit_good",  int'(bus.hit_good),  e.hg);
                chk("hit_bad",   int'(bus.hit_bad),   e.hb);
            end
        end
    end

    task automatic drive_cycle(input int mode, input int cyc);
        bit [N-1:0] sg, sb, h;
        sg = '0; sb = '0; h = bus.hit;
        case (mode)
            1: begin
                sg = '1;
                h  = (cyc % 2 == 0) ? '1 : '0;
            end
            2: begin
                sb = '1;
                h  = (cyc % 2 == 0) ? '1 : '0;
            end
            default: begin
                for (int i = 0; i < N; i++) begin
                    sg[i] = ($urandom_range(0, 11) == 0);
                    sb[i] = ($urandom_range(0, 15) == 0);
                    if ($urandom_range(0, 5) == 0) h[i] = ~h[i];
                end
            end
        endcase
        bus.spawn_good = sg;
        bus.spawn_bad  = sb;
        bus.hit        = h;
        bus.clear      = (mode == 0 || mode == 3) && ($urandom_range(0, 299) == 0);
        if (mode == 3 && $urandom_range(0, 29) == 0) bus.enable = ~bus.enable;
        if (mode != 3) bus.enable = 1'b1;
    endtask

    initial begin
        int rst_left;
        exp_t e;
        tests_run = 0; tests_failed = 0;
        set_n = 1'b0;
        bus.enable = 1'b0; bus.clear = 1'b0;
        bus.spawn_good = '0; bus.spawn_bad = '0; bus.hit = '0;
        model_reset();
        rst_left = 3;
        for (int phase = 0; phase < 5; phase++) begin
            int mode, ncyc;
            case (phase)
                0: begin mode = 0; ncyc = 1500; end
                1: begin mode = 1; ncyc = 200;  end
                2: begin mode = 2; ncyc = 450;  end
                3: begin mode = 3; ncyc = 1200; end
                default: begin mode = 0; ncyc = 800; end
            endcase
            for (int c = 0; c < ncyc; c++) begin
                @(negedge clk);
                drive_cycle(mode, c);
                if (rst_left > 0) begin
                    rst_left--;
                    set_n = 1'b0;
                end else begin
                    set_n = 1'b1;
                    if (mode == 0 && $urandom_range(0, 399) == 0) begin
                        set_n    = 1'b0;
                        rst_left = 2;
                    end
                end
                model_edge();
                e = model_view();
                exp_q.push_back(e);
            end
        end
        @(posedge clk);
        #2;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire
